// File: rtl/word_serializer.sv
// Parallel-in, serial-out stage with a valid/ready input handshake.
// Emits an accepted N-bit word one bit per clock, MSB-first or LSB-first.
module word_serializer #(
  parameter int unsigned N  = 32,
  parameter int unsigned CW = $clog2(N)
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         in_dir,
  output logic         ser_out,
  output logic         ser_valid,
  output logic         frame_start,
  output logic         frame_done
);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  sreg_q, sreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dir_q, dir_d;

  logic shifting;
  logic last_bit;
  logic accept;

  assign shifting = (state_q == StShift);
  assign last_bit = shifting && (cnt_q == CW'(N - 1));
  assign accept   = in_valid && in_ready;

  // The last-bit cycle also accepts, so frames can run back to back.
  assign in_ready    = (state_q == StIdle) || last_bit;
  assign ser_valid   = shifting;
  assign frame_start = shifting && (cnt_q == '0);
  assign frame_done  = last_bit;
  assign ser_out     = shifting && (dir_q ? sreg_q[N-1] : sreg_q[0]);

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    if (accept) begin
      state_d = StShift;
      sreg_d  = in_data;
      dir_d   = in_dir;
      cnt_d   = '0;
    end else if (shifting) begin
      sreg_d = dir_q ? {sreg_q[N-2:0], 1'b0} : {1'b0, sreg_q[N-1:1]};
      if (last_bit) begin
        state_d = StIdle;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= StIdle;
      sreg_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer (N=8): expected frame bits are queued at
// stimulus time and popped by a negedge monitor as the DUT shifts them out.
module tb_word_serializer;

  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         clr;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         in_dir;
  logic         ser_out;
  logic         ser_valid;
  logic         frame_start;
  logic         frame_done;

  typedef struct packed {
    logic b;
    logic s;
    logic d;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   run_len  = 0;
  int   last_run = 0;
  int   done_cnt = 0;
  bit   mon_en   = 1'b0;

  word_serializer #(.N(N)) dut (
    .clk        (clk),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_dir     (in_dir),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .frame_start(frame_start),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [N-1:0] d, input logic dir);
    for (int i = 0; i < int'(N); i++) begin
      exp_t e;
      e.b = dir ? d[N-1-i] : d[i];
      e.s = (i == 0);
      e.d = (i == int'(N) - 1);
      exp_q.push_back(e);
    end
  endtask

  // Drives one word for a single edge; caller guarantees in_ready at that edge.
  task automatic send(input logic [N-1:0] d, input logic dir);
    in_valid = 1'b1;
    in_data  = d;
    in_dir   = dir;
    push_frame(d, dir);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag, input int run, input int dones);
    @(negedge clk); #1;
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_valid"}, 32'(ser_valid), 32'd0);
    chk({tag, "_qempty"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_run"}, 32'(last_run), 32'(run));
    chk({tag, "_dones"}, 32'(done_cnt), 32'(dones));
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (ser_valid) begin
        run_len++;
        if (frame_done) done_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_bit", 32'(ser_valid), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("ser_out", 32'(ser_out), 32'(e.b));
          chk("frame_start", 32'(frame_start), 32'(e.s));
          chk("frame_done", 32'(frame_done), 32'(e.d));
        end
      end else begin
        if (run_len > 0) last_run = run_len;
        run_len = 0;
        chk("idle_outs", {29'd0, ser_out, frame_start, frame_done}, 32'd0);
      end
    end
  end

  initial begin
    clr      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_dir   = 1'b0;
    cycles(2);
    @(negedge clk);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_outs", {28'd0, ser_valid, ser_out, frame_start, frame_done}, 32'd0);
    @(posedge clk); #1;
    clr    = 1'b0;
    mon_en = 1'b1;

    // 1: MSB-first
    send(8'hB4, 1'b1);
    cycles(8);
    check_idle("t1", 8, 1);

    // 2: LSB-first
    send(8'hB4, 1'b0);
    cycles(8);
    check_idle("t2", 8, 2);

    // 3: back-to-back frames, second word accepted on the last-bit cycle
    in_valid = 1'b1;
    in_data  = 8'h0F;
    in_dir   = 1'b1;
    push_frame(8'h0F, 1'b1);
    @(posedge clk); #1;
    in_data = 8'hF0;
    in_dir  = 1'b0;
    push_frame(8'hF0, 1'b0);
    cycles(8);
    in_valid = 1'b0;
    cycles(8);
    check_idle("t3", 16, 4);

    // 4: in_valid while busy is ignored
    send(8'h00, 1'b1);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    in_dir   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4_busy_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    cycles(4);
    check_idle("t4", 8, 5);

    // 5: reset during bit 3 aborts the frame
    send(8'hAA, 1'b1);
    cycles(3);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("t5_abort_valid", 32'(ser_valid), 32'd0);
    chk("t5_abort_ready", 32'(in_ready), 32'd1);
    chk("t5_abort_dones", 32'(done_cnt), 32'd5);
    @(posedge clk); #1;
    send(8'h81, 1'b1);
    cycles(8);
    check_idle("t5", 8, 6);

    // 6: reset wins over a same-cycle accept
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h55;
    in_dir   = 1'b1;
    @(posedge clk); #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("t6_valid", 32'(ser_valid), 32'd0);
    chk("t6_ready", 32'(in_ready), 32'd1);
    cycles(2);
    check_idle("t6", 8, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
